// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
package dmem_pkg;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;
    localparam logic CORE = 1'b0;
    localparam logic DBG = 1'b1;
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic req, we, dbl, ack, stall;
    logic [ADDR_W-1:0] addr;
    logic [2*DATA_W-1:0] wdata, rdata;
    modport master (output req, we, dbl, addr, wdata, input ack, rdata, stall);
    modport slave (input req, we, dbl, addr, wdata, output ack, rdata, stall);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes to the port not served last.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;
    always_comb gnt = !en ? 2'b00 : (&req) ? (last == DBG ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= DBG;
        else if (|gnt) last <= gnt[DBG];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between core and debug ports,
// splitting 64-bit accesses into two word beats and acking one cycle after DONE.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     core,
    dmem_arbiter_if.slave     dbg,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Data2Mem,
    input  logic [DATA_W-1:0] ReadDataMem,
    output logic              busy
);
    state_t state, next;
    logic [1:0] elig, gnt;
    logic c_we, c_dbl, c_port;
    logic [ADDR_W-1:0] c_addr;
    logic [2*DATA_W-1:0] c_wdata, rd_word, core_rdata, dbg_rdata;
    logic [DATA_W-1:0] rd_lo;
    logic core_ack, dbg_ack;

    // a port is masked during its own ack cycle so it cannot be re-granted on a stale req
    assign elig = {dbg.req & ~dbg_ack, core.req & ~core_ack};

    rr_arb2 u_arb (
        .clk(clk),
        .rst(rst),
        .en(state == IDLE),
        .req(elig),
        .gnt(gnt)
    );

    always_comb begin
        next = state;
        CEN = 1'b1;
        WEN = 1'b1;
        OEN = 1'b1;
        A = '0;
        Data2Mem = '0;
        case (state)
            IDLE: next = |gnt ? BEAT0 : IDLE;
            BEAT0: begin
                CEN = 1'b0;
                WEN = ~c_we;
                OEN = c_we;
                A = c_addr;
                Data2Mem = c_we ? c_wdata[DATA_W-1:0] : '0;
                next = c_dbl ? BEAT1 : DONE;
            end
            BEAT1: begin
                CEN = 1'b0;
                WEN = ~c_we;
                OEN = c_we;
                A = c_addr + ADDR_W'(1);
                Data2Mem = c_we ? c_wdata[2*DATA_W-1:DATA_W] : '0;
                next = DONE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_port <= CORE;
            c_we <= 1'b0;
            c_dbl <= 1'b0;
            c_addr <= '0;
            c_wdata <= '0;
        end else if (state == IDLE && |gnt) begin
            c_port <= gnt[DBG];
            c_we <= gnt[DBG] ? dbg.we : core.we;
            c_dbl <= gnt[DBG] ? dbg.dbl : core.dbl;
            c_addr <= gnt[DBG] ? dbg.addr : core.addr;
            c_wdata <= gnt[DBG] ? dbg.wdata : core.wdata;
        end
    end

    // read data lags the access beat by one cycle: beat0 lands in BEAT1, the last beat in DONE
    assign rd_word = c_dbl ? {ReadDataMem, rd_lo} : {{DATA_W{1'b0}}, ReadDataMem};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_lo <= '0;
            core_ack <= 1'b0;
            dbg_ack <= 1'b0;
            core_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            if (state == BEAT1 && !c_we) rd_lo <= ReadDataMem;
            core_ack <= state == DONE && c_port == CORE;
            dbg_ack <= state == DONE && c_port == DBG;
            if (state == DONE && !c_we && c_port == CORE) core_rdata <= rd_word;
            if (state == DONE && !c_we && c_port == DBG) dbg_rdata <= rd_word;
        end
    end

    assign core.ack = core_ack;
    assign dbg.ack = dbg_ack;
    assign core.rdata = core_rdata;
    assign dbg.rdata = dbg_rdata;
    assign core.stall = core.req & ~core_ack;
    assign dbg.stall = dbg.req & ~dbg_ack;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus checked against a transaction-timeline model of the arbiter.
module tb_dmem_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic CEN, WEN, OEN, busy;
    logic [AW-1:0] A;
    logic [DW-1:0] Data2Mem;
    logic [DW-1:0] ReadDataMem = '0;
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) core_if ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_if ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .core(core_if), .dbg(dbg_if),
        .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
        .ReadDataMem(ReadDataMem), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [128];
    logic [DW-1:0] mm [128];
    always @(posedge clk) begin
        if (!CEN && !WEN) mem[A] <= Data2Mem;
        if (!CEN && !OEN) ReadDataMem <= mem[A];
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Model: one transaction in flight; granted at cycle g it owns beats g+1..g+len,
    // DONE at g+len+1 and acks at g+len+2, when the arbiter is free again.
    logic p_act = 1'b0, p_port = 1'b0, p_we = 1'b0, m_last = 1'b1, g = 1'b0;
    int p_g = 0, p_len = 0, p_addr = 0, b = 0;
    logic [63:0] p_wd = '0, p_val = '0;
    logic [63:0] e_rd [2];
    logic [1:0] e_ack, elig;
    logic e_cen, e_wen, e_oen, e_busy, d_chk;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;

    task automatic model_reset();
        p_act = 1'b0;
        m_last = 1'b1;
        e_rd[0] = '0;
        e_rd[1] = '0;
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        else begin
            e_cen = 1; e_wen = 1; e_oen = 1; e_a = '0; e_d = '0; d_chk = 1; e_busy = 0; e_ack = '0;
            if (p_act) begin
                b = cyc - p_g - 1;
                if (b >= 0 && b < p_len) begin
                    e_cen = 0;
                    e_a = AW'((p_addr + b) % 128);
                    if (p_we) begin e_wen = 0; e_d = b == 0 ? p_wd[31:0] : p_wd[63:32]; end
                    else begin e_oen = 0; d_chk = 0; end
                end
                e_busy = cyc > p_g && cyc <= p_g + p_len + 1;
                if (cyc == p_g + p_len + 2) begin
                    e_ack[p_port] = 1'b1;
                    if (!p_we) e_rd[p_port] = p_val;
                    p_act = 1'b0;
                end
            end
            chk("CEN", 64'(CEN), 64'(e_cen));
            chk("WEN", 64'(WEN), 64'(e_wen));
            chk("OEN", 64'(OEN), 64'(e_oen));
            chk("A", 64'(A), 64'(e_a));
            if (d_chk) chk("Data2Mem", 64'(Data2Mem), 64'(e_d));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("core_ack", 64'(core_if.ack), 64'(e_ack[0]));
            chk("dbg_ack", 64'(dbg_if.ack), 64'(e_ack[1]));
            chk("core_rdata", core_if.rdata, e_rd[0]);
            chk("dbg_rdata", dbg_if.rdata, e_rd[1]);
            chk("core_stall", 64'(core_if.stall), 64'(core_if.req & ~e_ack[0]));
            chk("dbg_stall", 64'(dbg_if.stall), 64'(dbg_if.req & ~e_ack[1]));
            elig = {dbg_if.req & ~e_ack[1], core_if.req & ~e_ack[0]};
            if (!p_act && elig != 2'b00) begin
                g = elig == 2'b11 ? ~m_last : elig[1];
                m_last = g;
                p_act = 1'b1;
                p_port = g;
                p_g = cyc;
                p_we = g ? dbg_if.we : core_if.we;
                p_len = (g ? dbg_if.dbl : core_if.dbl) ? 2 : 1;
                p_addr = int'(g ? dbg_if.addr : core_if.addr);
                p_wd = g ? dbg_if.wdata : core_if.wdata;
                if (p_we) begin
                    mm[p_addr] = p_wd[31:0];
                    if (p_len == 2) mm[(p_addr + 1) % 128] = p_wd[63:32];
                end else
                    p_val = p_len == 2 ? {mm[(p_addr + 1) % 128], mm[p_addr]} : {32'h0, mm[p_addr]};
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive(bit p, bit we, bit dbl, logic [AW-1:0] addr, logic [63:0] wd, bit req);
        if (p) begin dbg_if.req = req; dbg_if.we = we; dbg_if.dbl = dbl; dbg_if.addr = addr; dbg_if.wdata = wd; end
        else begin core_if.req = req; core_if.we = we; core_if.dbl = dbl; core_if.addr = addr; core_if.wdata = wd; end
    endtask

    bit order[$];
    task automatic wait_ack(bit p, int lim);
        bit seen = 0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            seen = (p ? dbg_if.ack : core_if.ack) === 1'b1;
        end
        if (seen) order.push_back(p);
        else begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: port %0d got no ack within %0d cycles", p, lim);
        end
    endtask

    int t0, t1;
    initial begin
        drive(0, 0, 0, '0, '0, 0);
        drive(1, 0, 0, '0, '0, 0);
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
        mem[5] = 32'hDEADBEEF;
        mem[10] = 32'hAAAA0001;
        mem[11] = 32'hBBBB0002;
        for (int i = 0; i < 128; i++) mm[i] = mem[i];
        repeat (2) @(negedge clk);
        chk("rst_CEN", 64'(CEN), 64'd1);
        chk("rst_A", 64'(A), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata", core_if.rdata, 64'd0);
        sync();
        rst = 1'b0;
        sync();
        // tie straight after reset: core first, dbg in core's ack cycle
        drive(0, 0, 0, 7'd5, '0, 1);
        drive(1, 0, 0, 7'd10, '0, 1);
        t0 = cyc;
        goto(t0 + 1);
        chk("tie_A_core_first", 64'(A), 64'd5);
        goto(t0 + 3);
        chk("tie_core_ack", 64'(core_if.ack), 64'd1);
        chk("tie_core_rdata", core_if.rdata, 64'h00000000_DEADBEEF);
        sync();
        core_if.req = 1'b0;
        goto(t0 + 6);
        chk("tie_dbg_ack", 64'(dbg_if.ack), 64'd1);
        chk("tie_dbg_rdata", dbg_if.rdata, 64'h00000000_AAAA0001);
        sync();
        dbg_if.req = 1'b0;
        sync();
        // core single read
        drive(0, 0, 0, 7'd5, '0, 1);
        t0 = cyc;
        goto(t0);
        chk("rd_stall_c0", 64'(core_if.stall), 64'd1);
        goto(t0 + 1);
        chk("rd_CEN", 64'(CEN), 64'd0);
        chk("rd_OEN", 64'(OEN), 64'd0);
        chk("rd_A", 64'(A), 64'd5);
        goto(t0 + 2);
        chk("rd_stall_c2", 64'(core_if.stall), 64'd1);
        goto(t0 + 3);
        chk("rd_ack", 64'(core_if.ack), 64'd1);
        chk("rd_rdata", core_if.rdata, 64'h00000000_DEADBEEF);
        chk("rd_stall_c3", 64'(core_if.stall), 64'd0);
        sync();
        core_if.req = 1'b0;
        sync();
        // double write wrapping 127 -> 0
        drive(0, 1, 1, 7'd127, 64'h11112222_33334444, 1);
        t0 = cyc;
        goto(t0 + 1);
        chk("dw_A0", 64'(A), 64'd127);
        chk("dw_D0", 64'(Data2Mem), 64'h33334444);
        chk("dw_WEN0", 64'(WEN), 64'd0);
        goto(t0 + 2);
        chk("dw_A1", 64'(A), 64'd0);
        chk("dw_D1", 64'(Data2Mem), 64'h11112222);
        chk("dw_WEN1", 64'(WEN), 64'd0);
        goto(t0 + 3);
        chk("dw_noack_c3", 64'(core_if.ack), 64'd0);
        goto(t0 + 4);
        chk("dw_ack", 64'(core_if.ack), 64'd1);
        chk("dw_rdata_kept", core_if.rdata, 64'h00000000_DEADBEEF);
        sync();
        core_if.req = 1'b0;
        sync();
        // core holds req through its ack
        drive(0, 0, 0, 7'd127, '0, 1);
        t0 = cyc;
        goto(t0 + 3);
        chk("hold_ack1", 64'(core_if.ack), 64'd1);
        chk("hold_rdata", core_if.rdata, 64'h00000000_33334444);
        goto(t0 + 4);
        chk("hold_no_regrant", 64'(CEN), 64'd1);
        goto(t0 + 5);
        chk("hold_beat0", 64'(CEN), 64'd0);
        goto(t0 + 7);
        chk("hold_ack2", 64'(core_if.ack), 64'd1);
        sync();
        core_if.req = 1'b0;
        sync();
        // double read
        drive(1, 0, 1, 7'd10, '0, 1);
        t0 = cyc;
        goto(t0 + 3);
        chk("dr_noack_c3", 64'(dbg_if.ack), 64'd0);
        goto(t0 + 4);
        chk("dr_ack", 64'(dbg_if.ack), 64'd1);
        chk("dr_rdata", dbg_if.rdata, 64'hBBBB0002_AAAA0001);
        sync();
        dbg_if.req = 1'b0;
        sync();
        // reset during BEAT1 of a double write
        drive(0, 1, 1, 7'd20, 64'h55556666_77778888, 1);
        t0 = cyc;
        goto(t0 + 1);
        sync();
        #2 rst = 1'b1;
        #1;
        chk("arst_CEN", 64'(CEN), 64'd1);
        chk("arst_WEN", 64'(WEN), 64'd1);
        chk("arst_A", 64'(A), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        core_if.req = 1'b0;
        sync();
        sync();
        rst = 1'b0;
        t1 = cyc;
        for (int i = 0; i < 5; i++) begin
            goto(t1 + i);
            chk("arst_no_ack", 64'(core_if.ack), 64'd0);
            chk("arst_idle", 64'(busy), 64'd0);
        end
        sync();
        // both ports requesting continuously: grants must alternate
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    drive(0, i[0], i[1], AW'(40 + 2 * i), {32'hC0DE0000 + i, 32'h0000C0DE + i}, 1);
                    wait_ack(0, 20);
                    sync();
                end
                core_if.req = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    drive(1, ~i[0], i[1], AW'(39 + 2 * i), {32'hDB600000 + i, 32'h000000DB + i}, 1);
                    wait_ack(1, 20);
                    sync();
                end
                dbg_if.req = 1'b0;
            end
        join
        for (int i = 1; i < order.size(); i++) chk("alternate", 64'(order[i]), 64'(!order[i - 1]));
        repeat (3) sync();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
